matmul_input_loader: RTL and testbench
======================================

Name: matmul_input_loader

Overview:
- Upstream stage of the 8x8 systolic matrix multiplier top.
- Accepts a valid/ready stream of DWIDTH-bit matrix elements: all of A first, then all of B.
- Packs elements 4 per word and drives the multiplier's BRAM write port (enable_writing_to_mem, addr_pi, data_pi, we_a, we_b).
- After the final write, hands control to the multiplier by holding start_mat_mul until done_mat_mul, then reports completion.

Parameters:
- DWIDTH, 16, element width in bits.
- AWIDTH, 7, BRAM word address width.
- NUM_WORDS_A, 16, packed words written for matrix A; legal range 1..2^AWIDTH.
- NUM_WORDS_B, 16, packed words written for matrix B; legal range 1..2^AWIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- go  in  1  one-cycle request to start a load; sampled in IDLE only.
- in_valid  in  1  element stream valid.
- in_data  in  DWIDTH  element value.
- in_ready  out  1  loader can accept an element.
- enable_writing_to_mem  out  1  selects addr_pi as the BRAM address.
- addr_pi  out  AWIDTH  BRAM word address.
- data_pi  out  4*DWIDTH  packed word.
- we_a  out  1  write strobe, A BRAMs.
- we_b  out  1  write strobe, B BRAMs.
- start_mat_mul  out  1  multiplier start, level.
- done_mat_mul  in  1  multiplier completion.
- busy  out  1  high in every state except IDLE.
- load_done  out  1  one-cycle pulse when the multiply completes.

Behaviour:
- Reset (async): state=IDLE; pack lane=0; word count=0. Every output 0: in_ready, enable_writing_to_mem, addr_pi, data_pi, we_a, we_b, start_mat_mul, busy, load_done. Any partial pack is discarded.
- States: IDLE, LOAD_A, LOAD_B, SETTLE, RUN, WAIT_DONE.
- IDLE:
  - in_ready=0.
  - go=1 moves to LOAD_A, sets enable_writing_to_mem=1, busy=1.
- LOAD_A / LOAD_B:
  - in_ready=1. Handshake is in_valid&&in_ready.
  - Element k of a group (k=0..3) goes into pack bits [(k+1)*DWIDTH-1 : k*DWIDTH].
  - On the cycle after the 4th handshake of a group, the loader registers the word into data_pi, drives addr_pi = word count, and pulses we_a (LOAD_A) or we_b (LOAD_B) for exactly one cycle.
  - in_ready stays high during that write. Back-to-back streaming runs at 1 element/cycle with no bubbles.
  - Word count increments per write.
  - After word NUM_WORDS_A-1 is written: word count resets to 0, lane resets to 0, state becomes LOAD_B. The first B element can be accepted on the same cycle as the last A write.
  - After word NUM_WORDS_B-1 is accepted into the pack: in_ready drops and state becomes SETTLE.
- SETTLE:
  - Lasts one cycle.
  - The final we_b write completes here with enable_writing_to_mem still 1.
  - Then enable_writing_to_mem goes to 0 and addr_pi to 0.
- RUN:
  - start_mat_mul goes to 1 and is held.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - done_mat_mul is ignored during the first cycle start_mat_mul is high.
  - After that, done_mat_mul=1 causes: start_mat_mul=0, load_done pulses for 1 cycle, busy=0, state becomes IDLE.
- The write address never exceeds NUM_WORDS_x-1, so there is no wrap. NUM_WORDS > 2^AWIDTH is illegal and trapped by a simulation-only check.
- go while busy is ignored. in_valid while IDLE/SETTLE/RUN/WAIT_DONE is not accepted (in_ready=0).
- Reset mid-load or mid-run: immediate return to IDLE with all outputs 0. Partially written BRAM contents are unspecified; the host must reload.
- we_a and we_b are never high on the same cycle. Neither is ever high while enable_writing_to_mem=0.

Optional Feature:
- Macro LOADER_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles (32 bits), reset 0.
  - Cleared on the go acceptance cycle.
  - Increments every cycle from entry to LOAD_A through the cycle done_mat_mul is accepted, then holds until the next go.
  - Saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single load: go; stream 128 elements at 1/cycle with values 0..127 -> exactly 16 we_a pulses at addr 0..15, then 16 we_b pulses at addr 0..15. Word 0 data_pi = 0x0003_0002_0001_0000. First B word = 0x0043_0042_0041_0040. start_mat_mul rises 2 cycles after the last we_b; done after 40 cycles -> load_done pulse, busy=0.
- Bubbled stream: in_valid toggled 1,0,0,1 repeatedly -> same addresses and data as the single-load test; no write strobe ever occurs without 4 accepted elements.
- go held high through the whole run plus a second go during WAIT_DONE -> exactly one load; after load_done with go=1 in IDLE, a new LOAD_A starts.
- Stale done: done_mat_mul tied high when RUN is entered -> start_mat_mul stays high for at least 2 cycles before load_done.
- Reset asserted after 37 elements -> all outputs 0 in the same cycle (async). A fresh go plus 128 elements reproduces the single-load results exactly.
- LOADER_PERF_CNT_EN with 128 back-to-back elements and done 40 cycles after start -> perf_cycles equals the measured LOAD_A-entry-to-done cycle count. The value holds until the next go.

Source files
------------

// File: rtl/matmul_input_loader.sv
// ---------------------------------------------------------------------------
// matmul_input_loader
//
// Front end of the 8x8 systolic matrix multiplier. It takes a valid/ready
// stream of DWIDTH-bit elements, all of matrix A followed by all of matrix B.
// It packs the elements four to a word and writes each word through the
// multiplier's BRAM write port. After the last B word it starts the
// multiplier and waits for it to report completion.
//
// Ports
//   clk, reset              clock (posedge) and asynchronous active-high reset
//   go                      one-cycle load request, sampled only in IDLE
//   in_valid/in_data        element stream from the host
//   in_ready                loader accepts an element this cycle
//   enable_writing_to_mem   BRAM address mux select (addr_pi owns the port)
//   addr_pi, data_pi        BRAM word address and packed word
//   we_a, we_b              one-cycle write strobes for the A and B BRAMs
//   start_mat_mul           level start to the multiplier
//   done_mat_mul            completion from the multiplier
//   busy                    high in every state except IDLE
//   load_done               one-cycle pulse when the multiply has completed
//   perf_cycles             (LOADER_PERF_CNT_EN only) busy-cycle counter
//
// Optional feature: define LOADER_PERF_CNT_EN to add the 32-bit perf_cycles
// output. It counts every non-IDLE cycle of the last load and saturates.
// ---------------------------------------------------------------------------
module matmul_input_loader #(
    parameter int DWIDTH      = 16,
    parameter int AWIDTH      = 7,
    parameter int NUM_WORDS_A = 16,
    parameter int NUM_WORDS_B = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  in_valid,
    input  logic [DWIDTH-1:0]     in_data,
    output logic                  in_ready,
    output logic                  enable_writing_to_mem,
    output logic [AWIDTH-1:0]     addr_pi,
    output logic [4*DWIDTH-1:0]   data_pi,
    output logic                  we_a,
    output logic                  we_b,
    output logic                  start_mat_mul,
    input  logic                  done_mat_mul,
    output logic                  busy,
    output logic                  load_done
`ifdef LOADER_PERF_CNT_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    // Index of the last word of each matrix. The legal range check below
    // guarantees that the value fits in AWIDTH bits.
    localparam logic [AWIDTH-1:0] LAST_A = AWIDTH'(NUM_WORDS_A - 1);
    localparam logic [AWIDTH-1:0] LAST_B = AWIDTH'(NUM_WORDS_B - 1);

`ifndef SYNTHESIS
    // Each word count must fit in the BRAM address space. A larger count
    // would wrap the write address and overwrite earlier words.
    if (NUM_WORDS_A < 1 || NUM_WORDS_A > (1 << AWIDTH)) begin : g_bad_num_words_a
        $error("matmul_input_loader: NUM_WORDS_A out of range 1..2^AWIDTH");
    end
    if (NUM_WORDS_B < 1 || NUM_WORDS_B > (1 << AWIDTH)) begin : g_bad_num_words_b
        $error("matmul_input_loader: NUM_WORDS_B out of range 1..2^AWIDTH");
    end
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_SETTLE,
        S_RUN,
        S_WAIT_DONE
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_lane;        // next pack lane to fill
    logic [AWIDTH-1:0]        r_wcnt;        // word index inside current matrix
    logic [2:0][DWIDTH-1:0]   r_pack;        // lanes 0..2; lane 3 comes straight from in_data
    logic                     r_first_wait;  // first cycle of start_mat_mul
    logic                     r_in_ready;
    logic                     r_enable;
    logic [AWIDTH-1:0]        r_addr;
    logic [4*DWIDTH-1:0]      r_data;
    logic                     r_we_a;
    logic                     r_we_b;
    logic                     r_start;
    logic                     r_busy;
    logic                     r_load_done;

    logic                     w_hs;
    logic                     w_word_done;

    assign w_hs        = in_valid && r_in_ready;
    // The fourth element does not wait in r_pack. It goes straight into
    // the output word, so the write starts on the next cycle with no bubble.
    assign w_word_done = w_hs && (r_lane == 2'd3);

    assign in_ready              = r_in_ready;
    assign enable_writing_to_mem = r_enable;
    assign addr_pi               = r_addr;
    assign data_pi               = r_data;
    assign we_a                  = r_we_a;
    assign we_b                  = r_we_b;
    assign start_mat_mul         = r_start;
    assign busy                  = r_busy;
    assign load_done             = r_load_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lane       <= 2'd0;
            r_wcnt       <= '0;
            r_pack       <= '0;
            r_first_wait <= 1'b0;
            r_in_ready   <= 1'b0;
            r_enable     <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we_a       <= 1'b0;
            r_we_b       <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            r_we_a      <= 1'b0;
            r_we_b      <= 1'b0;
            r_load_done <= 1'b0;

            if (w_hs) begin
                for (int k = 0; k < 3; k++) begin
                    if (r_lane == 2'(k)) r_pack[k] <= in_data;
                end
                r_lane <= r_lane + 2'd1;
            end

            if (w_word_done) begin
                r_data <= {in_data, r_pack[2], r_pack[1], r_pack[0]};
                r_addr <= r_wcnt;
                r_we_a <= (r_state == S_LOAD_A);
                r_we_b <= (r_state == S_LOAD_B);
            end

            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state    <= S_LOAD_A;
                        r_enable   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_lane     <= 2'd0;
                        r_wcnt     <= '0;
                    end
                end

                S_LOAD_A: begin
                    if (w_word_done) begin
                        if (r_wcnt == LAST_A) begin
                            // The last A word is written on the next cycle,
                            // while the stream has already moved on to B.
                            r_wcnt  <= '0;
                            r_lane  <= 2'd0;
                            r_state <= S_LOAD_B;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end

                S_LOAD_B: begin
                    if (w_word_done) begin
                        if (r_wcnt == LAST_B) begin
                            r_wcnt     <= '0;
                            r_lane     <= 2'd0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_SETTLE;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end

                S_SETTLE: begin
                    // The final we_b is on the port during this cycle. Give
                    // the BRAM address back to the multiplier only after it.
                    r_enable <= 1'b0;
                    r_addr   <= '0;
                    r_state  <= S_RUN;
                end

                S_RUN: begin
                    r_start      <= 1'b1;
                    r_first_wait <= 1'b1;
                    r_state      <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    // A done left high by the previous run must not end this
                    // run, so the first start cycle ignores done.
                    if (r_first_wait) begin
                        r_first_wait <= 1'b0;
                    end else if (done_mat_mul) begin
                        r_start     <= 1'b0;
                        r_load_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_PERF_CNT_EN
    logic [31:0] r_perf;

    assign perf_cycles = r_perf;

    // Counts every non-IDLE cycle, including the cycle that accepts done.
    // The value then holds until the next go clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf <= '0;
        end else if (r_state == S_IDLE) begin
            if (go) r_perf <= '0;
        end else if (r_perf != 32'hFFFF_FFFF) begin
            r_perf <= r_perf + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_input_loader.sv
module tb_matmul_input_loader;

    localparam int DW       = 16;
    localparam int AW       = 7;
    localparam int NWA      = 16;
    localparam int NWB      = 16;
    localparam int NEL      = 4 * (NWA + NWB);
    localparam int DONE_DLY = 40;

    logic               clk;
    logic               reset;
    logic               go;
    logic               in_valid;
    logic [DW-1:0]      in_data;
    logic               in_ready;
    logic               enable_writing_to_mem;
    logic [AW-1:0]      addr_pi;
    logic [4*DW-1:0]    data_pi;
    logic               we_a;
    logic               we_b;
    logic               start_mat_mul;
    logic               done_mat_mul;
    logic               busy;
    logic               load_done;
`ifdef LOADER_PERF_CNT_EN
    logic [31:0]        perf_cycles;
`endif

    matmul_input_loader #(
        .DWIDTH(DW), .AWIDTH(AW), .NUM_WORDS_A(NWA), .NUM_WORDS_B(NWB)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .enable_writing_to_mem(enable_writing_to_mem),
        .addr_pi(addr_pi), .data_pi(data_pi), .we_a(we_a), .we_b(we_b),
        .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
        .busy(busy), .load_done(load_done)
`ifdef LOADER_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected BRAM writes, in the order they must appear.
    typedef struct {
        bit          is_b;
        int          addr;
        logic [63:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t cur;

    logic [DW-1:0] elems [NEL];

    // Monitor statistics, cleared at the start and end of each load.
    int     ncyc = 0;
    int     acc, nwr, na, nb, start_hi, busy_cnt, last_web;
    logic   prev_start = 1'b0;
    logic [63:0] cap_a0, cap_b0;
    bit     done_tied = 0;
    bit     go_hold   = 0;

    task automatic clr_stats();
        acc = 0; nwr = 0; na = 0; nb = 0; start_hi = 0; busy_cnt = 0;
        last_web = -100; cap_a0 = '0; cap_b0 = '0;
    endtask

    // Monitor: compares each BRAM write with the scoreboard queue, and
    // records cycle-level facts that the stimulus checks at the end of a load.
    always @(negedge clk) begin
        if (!reset) begin
            if (we_a || we_b) begin
                chk("we_exclusive", 64'(we_a && we_b), 0);
                chk("we_with_enable", 64'(enable_writing_to_mem), 1);
                chk("four_elems_before_write", 64'(acc >= 4 * (nwr + 1)), 1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual_addr=%0d required=none", addr_pi);
                end else begin
                    cur = exp_q.pop_front();
                    chk("wr_kind_b", 64'(we_b), 64'(cur.is_b));
                    chk("wr_addr", 64'(addr_pi), 64'(cur.addr));
                    chk("wr_data", data_pi, cur.data);
                end
                if (we_a && addr_pi == 0) cap_a0 = data_pi;
                if (we_b && addr_pi == 0) cap_b0 = data_pi;
                if (we_a) na++; else nb++;
                if (we_b) last_web = ncyc;
                nwr++;
            end
            if (in_valid && in_ready) acc++;
            if (start_mat_mul && !prev_start) chk("start_after_last_we_b", 64'(ncyc - last_web), 2);
            if (start_mat_mul) start_hi++;
            if (busy) busy_cnt++;
            prev_start = start_mat_mul;
        end
        ncyc++;
    end

    // Multiplier model: done comes after start has been high DONE_DLY cycles,
    // or is held high for the stale-done test.
    int start_cnt = 0;
    initial begin
        done_mat_mul = 1'b0;
        forever begin
            @(negedge clk);
            if (done_tied) begin
                done_mat_mul = 1'b1;
            end else if (start_mat_mul) begin
                start_cnt++;
                done_mat_mul = (start_cnt == DONE_DLY);
            end else begin
                start_cnt = 0;
                done_mat_mul = 1'b0;
            end
        end
    end

    // Fill the element list and push the expected words. Element 4w+k sits
    // in lane k of word w. Words 0..NWA-1 go to A; the rest go to B.
    task automatic prep(input bit seq_vals, input int n_el);
        logic [63:0] w;
        for (int i = 0; i < NEL; i++) elems[i] = seq_vals ? DW'(i) : DW'($urandom);
        for (int wi = 0; wi < n_el / 4; wi++) begin
            w = 0;
            for (int k = 0; k < 4; k++) w = w + (64'(elems[4*wi+k]) << (DW * k));
            exp_q.push_back('{is_b: (wi >= NWA), addr: (wi >= NWA) ? wi - NWA : wi, data: w});
        end
    endtask

    // Drive one load. Inputs change on negedges. A handshake is decided by
    // in_ready, which is stable during the low half of the clock.
    task automatic run_load(input bit issue_go, input bit bubble, input bit seq_vals,
                            input int n_el, input bit finish);
        int  idx = 0;
        int  t   = 0;
        int  n   = 0;
        bit  a;
        bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        prep(seq_vals, n_el);
        if (issue_go) begin
            clr_stats();
            go = 1'b1;
            @(negedge clk);
            if (!go_hold) go = 1'b0;
        end
        while (idx < n_el && t < 4000) begin
            in_valid = bubble ? pat[t % 4] : 1'b1;
            in_data  = in_valid ? elems[idx] : DW'($urandom);
            a = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (a) idx++;
            t++;
        end
        in_valid = 1'b0;
        if (idx != n_el) chk("stream_timeout", 64'(idx), 64'(n_el));
        if (finish) begin
            while (!load_done && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk("load_done_seen", 64'(load_done), 1);
            chk("busy_low_at_done", 64'(busy), 0);
            chk("start_low_at_done", 64'(start_mat_mul), 0);
            chk("queue_drained", 64'(exp_q.size()), 0);
            chk("num_we_a", 64'(na), NWA);
            chk("num_we_b", 64'(nb), NWB);
            if (done_tied) chk("stale_done_start_hold", 64'(start_hi >= 2), 1);
            else           chk("start_high_cycles", 64'(start_hi), DONE_DLY);
            if (seq_vals) begin
                chk("a_word0", cap_a0, 64'h0003_0002_0001_0000);
                chk("b_word0", cap_b0, 64'h0043_0042_0041_0040);
            end
`ifdef LOADER_PERF_CNT_EN
            chk("perf_cycles", 64'(perf_cycles), 64'(busy_cnt));
            if (!go_hold) begin
                repeat (3) @(negedge clk);
                chk("perf_hold", 64'(perf_cycles), 64'(busy_cnt));
            end
`endif
            clr_stats();
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0;
        clr_stats();
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(|{in_ready, enable_writing_to_mem, addr_pi, data_pi,
                                   we_a, we_b, start_mat_mul, busy, load_done}), 0);
        reset = 1'b0;
        @(negedge clk);

        run_load(1, 0, 1, NEL, 1);   // single load, values 0..127
        run_load(1, 1, 1, NEL, 1);   // bubbled stream
        run_load(1, 0, 0, NEL, 1);   // random values, back-to-back
        run_load(1, 1, 0, NEL, 1);   // random values, bubbled

        // go held high through the load and WAIT_DONE: one load, then a new
        // load starts straight from IDLE.
        go_hold = 1;
        run_load(1, 0, 0, NEL, 1);
        @(negedge clk);
        chk("go_restart_busy", 64'(busy), 1);
        chk("go_restart_ready", 64'(in_ready), 1);
        go_hold = 0;
        go = 1'b0;
        run_load(0, 0, 0, NEL, 1);

        // done already high when RUN is entered
        done_tied = 1;
        run_load(1, 0, 0, NEL, 1);
        done_tied = 0;
        repeat (2) @(negedge clk);

        // reset in the middle of A
        run_load(1, 0, 1, 37, 0);
        chk("partial_writes_seen", 64'(exp_q.size()), 0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'(|{in_ready, enable_writing_to_mem, addr_pi, data_pi,
                                         we_a, we_b, start_mat_mul, busy, load_done}), 0);
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 64'(busy), 0);
        run_load(1, 0, 1, NEL, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
